// File: rtl/vga_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_write_arbiter_if
// Description : Engine-side write bus and VGA-side pixel port of the
//               frame-buffer write arbiter, bundled into one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_write_arbiter_if #(
    parameter int N        = 3,
    parameter int COLOUR_W = 1
);
    // Engine side (driven by the pixel-writing engines)
    logic [N-1:0]          req;
    logic [N-1:0]          release_burst;
    logic [N-1:0]          wr_en;
    logic [N*10-1:0]       wr_x;
    logic [N*9-1:0]        wr_y;
    logic [N*COLOUR_W-1:0] wr_colour;

    // Arbiter side (grant status and the shared VGA write port)
    logic [N-1:0]          grant;
    logic [9:0]            vga_x;
    logic [8:0]            vga_y;
    logic [COLOUR_W-1:0]   vga_in;
    logic                  vga_wren;
    logic                  busy;
    logic                  timeout_err;

    modport master (
        output req, release_burst, wr_en, wr_x, wr_y, wr_colour,
        input  grant, vga_x, vga_y, vga_in, vga_wren, busy, timeout_err
    );

    modport slave (
        input  req, release_burst, wr_en, wr_x, wr_y, wr_colour,
        output grant, vga_x, vga_y, vga_in, vga_wren, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/vga_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_write_arbiter
// Description : Round-robin, burst-granular arbiter sharing the single VGA
//               frame-buffer write port between N pixel engines. A granted
//               engine keeps the port until it releases it or drops req; a
//               hold watchdog bounds every grant. One idle turnaround cycle
//               follows each grant.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_write_arbiter #(
    parameter int N        = 3,
    parameter int COLOUR_W = 1,
    parameter int MAX_HOLD = 4096
) (
    input  logic               clk,
    input  logic               program_resetn,
    vga_write_arbiter_if.slave bus
);

    localparam int c_PTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam int c_HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [c_PTR_W:0]    c_N_EXT     = (c_PTR_W + 1)'(N);
    localparam logic [c_PTR_W-1:0]  c_LAST_IDX  = c_PTR_W'(N - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = (MAX_HOLD > 0) ? c_HOLD_W'(MAX_HOLD - 1) : '0;
    localparam logic [c_HOLD_W-1:0] c_HOLD_SAT  = '1;
    localparam logic                c_WD_ON     = (MAX_HOLD != 0);
    localparam logic [N-1:0]        c_ONE       = {{(N-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GRANT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    logic [1:0]          r_state;
    logic [c_PTR_W-1:0]  r_rr_ptr;
    logic [c_PTR_W-1:0]  r_owner;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [N-1:0]        r_grant;
    logic                r_busy;
    logic                r_timeout_err;
    logic [9:0]          r_vga_x;
    logic [8:0]          r_vga_y;
    logic [COLOUR_W-1:0] r_vga_in;
    logic                r_vga_wren;

    logic [1:0]          w_state_nxt;
    logic [c_PTR_W-1:0]  w_rr_nxt;
    logic [c_PTR_W-1:0]  w_owner_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [N-1:0]        w_grant_nxt;
    logic                w_busy_nxt;
    logic                w_timeout_nxt;

    logic                w_found;
    logic [c_PTR_W-1:0]  w_pick;
    logic [c_PTR_W:0]    w_sum;
    logic [c_PTR_W:0]    w_wrap;
    logic [c_PTR_W-1:0]  w_owner_inc;
    logic                w_wd_fire;
    logic                w_end;
    logic                w_owner_wr;

    logic [9:0]          w_x_arr   [N];
    logic [8:0]          w_y_arr   [N];
    logic [COLOUR_W-1:0] w_col_arr [N];

    // Unpack per-engine fields so the owner's pixel can be selected by index
    generate
        for (genvar k = 0; k < N; k++) begin : g_unpack
            assign w_x_arr[k]   = bus.wr_x[10*k +: 10];
            assign w_y_arr[k]   = bus.wr_y[9*k +: 9];
            assign w_col_arr[k] = bus.wr_colour[COLOUR_W*k +: COLOUR_W];
        end
    endgenerate

    assign w_owner_inc = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;
    assign w_wd_fire   = c_WD_ON && (r_hold_cnt == c_HOLD_LAST);
    assign w_end       = bus.release_burst[r_owner] | ~bus.req[r_owner] | w_wd_fire;
    assign w_owner_wr  = (r_state == c_ST_GRANT) && bus.wr_en[r_owner];

    // Round-robin scan: first requester at or after the pointer, modulo N
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_sum   = '0;
        w_wrap  = '0;
        for (int i = 0; i < N; i++) begin
            w_sum  = {1'b0, r_rr_ptr} + (c_PTR_W + 1)'(i);
            w_wrap = (w_sum >= c_N_EXT) ? (w_sum - c_N_EXT) : w_sum;
            if (!w_found && bus.req[w_wrap[c_PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_wrap[c_PTR_W-1:0];
            end
        end
    end

    // Next-state and grant control for IDLE -> GRANT -> GAP -> IDLE
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr_ptr;
        w_owner_nxt   = r_owner;
        w_hold_nxt    = r_hold_cnt;
        w_grant_nxt   = r_grant;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = r_timeout_err;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_ST_GRANT;
                    w_owner_nxt = w_pick;
                    w_grant_nxt = c_ONE << w_pick;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = '0;
                end
            end
            c_ST_GRANT: begin
                if (w_wd_fire) begin
                    w_timeout_nxt = 1'b1;
                end
                if (w_end) begin
                    w_state_nxt = c_ST_GAP;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_rr_nxt    = w_owner_inc;
                    w_hold_nxt  = '0;
                end else if (r_hold_cnt != c_HOLD_SAT) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            c_ST_GAP: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            r_state       <= c_ST_IDLE;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_nxt;
            r_owner       <= w_owner_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_grant       <= w_grant_nxt;
            r_busy        <= w_busy_nxt;
            r_timeout_err <= w_timeout_nxt;
        end
    end

    // VGA write port: forward only the owner's strobed pixel, hold coords otherwise
    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            r_vga_x    <= '0;
            r_vga_y    <= '0;
            r_vga_in   <= '0;
            r_vga_wren <= 1'b0;
        end else begin
            r_vga_wren <= w_owner_wr;
            if (w_owner_wr) begin
                r_vga_x  <= w_x_arr[r_owner];
                r_vga_y  <= w_y_arr[r_owner];
                r_vga_in <= w_col_arr[r_owner];
            end
        end
    end

    assign bus.grant       = r_grant;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;
    assign bus.vga_x       = r_vga_x;
    assign bus.vga_y       = r_vga_y;
    assign bus.vga_in      = r_vga_in;
    assign bus.vga_wren    = r_vga_wren;

endmodule
`default_nettype wire
